reg_dump_reader: RTL and testbench

//   Read-side sequencer for the register file: on command, walks a range of register addresses

---
 rtl/reg_dump_pkg.sv | 6 +
 rtl/reg_dump_reader.sv | 87 ++++++++
 tb/tb_reg_dump_reader.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: dump sequencer state type and register-file geometry shared with the reg file
package reg_dump_pkg;
    localparam int DEF_PW = 4;
    localparam int DEF_DW = 8;
    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} dump_state_t;
endpackage

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a register range through a combinational read port, streams it out, flags stale captures
module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int PW = DEF_PW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [PW-1:0] first_addr,
    input  logic [PW-1:0] last_addr,
    input  logic          abort,
    output logic [PW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [PW-1:0] out_addr,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          stale
);
    dump_state_t state, state_d;
    logic [PW-1:0] addr, last;
    logic [2**PW-1:0] emitted;

    assign busy    = state != IDLE;
    assign done    = state == DONE;
    assign rd_addr = busy ? addr : '0;

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_d;

    // out_valid is always high in SEND, so out_ready alone completes the handshake there
    always_comb begin
        state_d = abort               ? IDLE :
                  state == IDLE       ? (start ? FETCH : IDLE) :
                  state == FETCH      ? SEND :
                  state == SEND       ? (out_ready ? (out_last ? DONE : FETCH) : SEND) :
                                        IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr      <= '0;
            last      <= '0;
            emitted   <= '0;
            stale     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (busy && wr_en && emitted[wr_addr])
                stale <= 1'b1;
            if (abort)
                out_valid <= 1'b0;
            else begin
                case (state)
                    IDLE: if (start) begin
                        addr    <= first_addr;
                        last    <= last_addr;
                        emitted <= '0;
                        stale   <= 1'b0;
                    end
                    FETCH: begin
                        out_data      <= rd_data;
                        out_addr      <= addr;
                        out_last      <= addr == last;
                        emitted[addr] <= 1'b1;
                        out_valid     <= 1'b1;
                    end
                    SEND: if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!out_last)
                            addr <= addr + PW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: directed range table plus hand sequences for backpressure, stale, abort, reset
module tb_reg_dump_reader;
    logic       clk = 0, reset = 1, start = 0, abort = 0, wr_en = 0, out_ready = 1;
    logic [3:0] first_addr = 0, last_addr = 0, rd_addr, wr_addr = 0, out_addr;
    logic [7:0] rd_data, out_data, wr_data = 0;
    logic       out_valid, out_last, busy, done, stale;
    logic [7:0] regs [16];
    int total = 0, bad = 0;

    typedef struct {int f; int l; int n;} vec_t;
    vec_t tbl [5];

    reg_dump_reader dut (
        .clk(clk), .reset(reset), .start(start), .first_addr(first_addr), .last_addr(last_addr),
        .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_last(out_last), .busy(busy), .done(done), .stale(stale)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (wr_en) regs[wr_addr] <= wr_data;

    assign rd_data = regs[rd_addr];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump(input int f, input int l);
        start = 1; first_addr = 4'(f); last_addr = 4'(l);
        tick();
        start = 0;
        chk("fetch_busy", busy, 1);
        chk("fetch_valid", out_valid, 0);
        chk("fetch_rd_addr", rd_addr, f);
    endtask

    // expects out_ready high; optionally writes register wa=wv while word index trig is presented
    task automatic collect(input int f, input int n, input int trig, input int wa, input int wv, input int c0);
        int got = 0;
        int cyc = c0;
        bit fin = 0;
        while (!fin && cyc < 200) begin
            if (out_valid) begin
                chk("word_cycle", cyc, 2 * got + 1);
                chk("word_addr", out_addr, (f + got) % 16);
                chk("word_data", out_data, regs[out_addr]);
                chk("word_last", out_last, got == n - 1);
                if (got == trig) begin
                    wr_en = 1; wr_addr = 4'(wa); wr_data = 8'(wv);
                end
                got++;
                fin = out_last;
            end
            tick();
            cyc++;
            wr_en = 0;
        end
        chk("word_count", got, n);
        chk("done_after_last", done, fin);
        if (fin) begin
            tick();
            chk("done_pulse_end", done, 0);
            chk("idle_after_done", busy, 0);
        end
    endtask

    initial begin
        bit seen;
        logic [7:0] hd;
        logic [3:0] ha;
        for (int i = 0; i < 16; i++) regs[i] = 8'((i * 37 + 11) & 255);
        tbl[0] = '{0, 15, 16};
        tbl[1] = '{14, 1, 4};
        tbl[2] = '{5, 5, 1};
        tbl[3] = '{3, 6, 4};
        tbl[4] = '{15, 0, 2};

        tick(); tick();
        reset = 0;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stale", stale, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_data", out_data, 0);

        for (int t = 0; t < 5; t++) begin
            start_dump(tbl[t].f, tbl[t].l);
            collect(tbl[t].f, tbl[t].n, -1, 0, 0, 0);
        end

        out_ready = 0;
        start_dump(5, 5);
        tick();
        chk("bp_valid", out_valid, 1);
        hd = out_data; ha = out_addr;
        chk("bp_addr", ha, 5);
        chk("bp_data", hd, regs[5]);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, hd);
            chk("bp_hold_addr", out_addr, ha);
            chk("bp_hold_last", out_last, 1);
        end
        out_ready = 1;
        tick();
        chk("bp_valid_drop", out_valid, 0);
        chk("bp_done", done, 1);
        tick();
        chk("bp_idle", busy, 0);

        start_dump(0, 7);
        collect(0, 8, 4, 7, 'h77, 0);
        chk("reg7_new_value", regs[7], 'h77);
        chk("stale_clean", stale, 0);
        start_dump(0, 7);
        collect(0, 8, 3, 2, 'hEE, 0);
        chk("stale_set", stale, 1);
        start_dump(4, 4);
        chk("stale_clear_on_start", stale, 0);
        collect(4, 1, -1, 0, 0, 0);

        start_dump(0, 3);
        start = 1; first_addr = 9; last_addr = 9;
        tick();
        start = 0;
        collect(0, 4, -1, 0, 0, 1);
        tick();
        chk("start_busy_ignored", busy, 0);

        start_dump(0, 7);
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (out_valid && out_addr == 3) begin
                seen = 1; abort = 1; out_ready = 0;
            end else tick();
        end
        chk("abort_reached_word3", seen, 1);
        tick();
        abort = 0; out_ready = 1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        tick();
        chk("abort_no_done", done, 0);
        start_dump(2, 3);
        collect(2, 2, -1, 0, 0, 0);

        start_dump(0, 15);
        tick();
        chk("rm_valid", out_valid, 1);
        wr_en = 1; wr_addr = 0; wr_data = 8'h42;
        tick();
        wr_en = 0;
        chk("rm_stale", stale, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("rm_out_valid", out_valid, 0);
        chk("rm_out_data", out_data, 0);
        chk("rm_out_addr", out_addr, 0);
        chk("rm_out_last", out_last, 0);
        chk("rm_busy", busy, 0);
        chk("rm_done", done, 0);
        chk("rm_stale_clr", stale, 0);
        chk("rm_rd_addr", rd_addr, 0);
        tick();
        chk("rm_no_done", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
